stream_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the source (write) port of a CDC FIFO between NUM_IN requesters.
- Uses valid/ready streaming handshakes and locks the grant for a whole burst, up to a configurable beat limit.
- Sits in the source clock domain, directly in front of the FIFO's valid/ready/data input.
- Data path is combinational; arbitration state is registered.

---
 rtl/stream_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_stream_rr_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter that feeds the write port of a CDC FIFO from NUM_IN
// streaming requesters. A grant is held for a whole burst (until last) or
// until MAX_BEATS beats have passed, whichever comes first. MAX_BEATS=0
// removes the beat limit. Payload routing is purely combinational; only the
// arbitration state (IDLE/LOCKED, rr pointer, locked index, beat count) is
// registered. busy_o is the FSM state and serves as its observation point.
//
// Handshake: a beat transfers on a rising clk_i edge where valid and ready
// are both high. Once offered, a beat stays on the output (the grant is
// locked) until it is accepted; valid never depends on ready.

module stream_rr_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 16,
  parameter int IDX_W      = $clog2(NUM_IN)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_IN-1:0]              inp_valid_i,
  output logic [NUM_IN-1:0]              inp_ready_o,
  input  logic [NUM_IN*DATA_WIDTH-1:0]   inp_data_i,
  input  logic [NUM_IN-1:0]              inp_last_i,
  output logic                           oup_valid_o,
  input  logic                           oup_ready_i,
  output logic [DATA_WIDTH-1:0]          oup_data_o,
  output logic                           oup_last_o,
  output logic [IDX_W-1:0]               oup_idx_o,
  output logic                           busy_o
);

  // Counter only needs to reach MAX_BEATS-1.
  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_lock_idx;
  logic [CNT_W-1:0]   r_beat_cnt;

  logic [IDX_W-1:0]   w_search_idx;
  logic               w_search_hit;
  logic               w_locked;
  logic [IDX_W-1:0]   w_grant;
  logic               w_have_grant;
  logic               w_valid;
  logic               w_hs;
  logic               w_limit;
  logic               w_end;

  // Index addition modulo NUM_IN (works for non-power-of-two NUM_IN).
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_IN) s = s - NUM_IN;
    return IDX_W'(s);
  endfunction

  // Cyclic priority search starting at rr_ptr; lowest offset wins.
  always_comb begin
    w_search_idx = r_rr_ptr;
    w_search_hit = 1'b0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (inp_valid_i[wrap_add(r_rr_ptr, i)]) begin
        w_search_hit = 1'b1;
        w_search_idx = wrap_add(r_rr_ptr, i);
      end
    end
  end

  // Grant selection, routing and end-of-grant detection.
  always_comb begin
    w_locked     = (r_state == ST_LOCKED);
    w_grant      = w_locked ? r_lock_idx : w_search_idx;
    w_have_grant = w_locked | w_search_hit;
    w_valid      = !rst_i && w_have_grant && inp_valid_i[w_grant];
    w_hs         = w_valid && oup_ready_i;
    w_limit      = (MAX_BEATS != 0) && ((int'(r_beat_cnt) + 1) == MAX_BEATS);
    w_end        = inp_last_i[w_grant] | w_limit;

    oup_valid_o  = w_valid;
    oup_data_o   = inp_data_i[int'(w_grant)*DATA_WIDTH +: DATA_WIDTH];
    oup_last_o   = inp_last_i[w_grant];
    oup_idx_o    = rst_i ? '0 : w_grant;
    busy_o       = w_locked;
    inp_ready_o  = '0;
    if (!rst_i && w_have_grant && oup_ready_i) inp_ready_o[w_grant] = 1'b1;
  end

  // Arbitration FSM: lock on stalled offer or mid-burst, release on last/limit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_lock_idx <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            if (!oup_ready_i) begin
              r_state    <= ST_LOCKED;
              r_lock_idx <= w_grant;
            end else if (!w_end) begin
              r_state    <= ST_LOCKED;
              r_lock_idx <= w_grant;
              r_beat_cnt <= CNT_W'(1);
            end else begin
              r_rr_ptr   <= wrap_add(w_grant, 1);
              r_beat_cnt <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (w_hs) begin
            if (!w_end) begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end else begin
              r_state    <= ST_IDLE;
              r_rr_ptr   <= wrap_add(r_lock_idx, 1);
              r_beat_cnt <= '0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: two instances (MAX_BEATS=16 and MAX_BEATS=4)
// each fed from their own per-requester beat queues, compared every cycle
// against a burst-level reference model (owner / beats-so-far / rr pointer).
module tb_stream_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    vld   [2];
  logic [N-1:0]    lst   [2];
  logic [N-1:0]    rdy_o [2];
  logic [N*DW-1:0] dat   [2];
  logic            ov    [2];
  logic            ordy  [2];
  logic [DW-1:0]   odat  [2];
  logic            olast [2];
  logic [1:0]      oidx  [2];
  logic            busy  [2];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  stream_rr_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW), .MAX_BEATS(16)) u_dut16 (
    .clk_i(clk), .rst_i(rst),
    .inp_valid_i(vld[0]), .inp_ready_o(rdy_o[0]), .inp_data_i(dat[0]), .inp_last_i(lst[0]),
    .oup_valid_o(ov[0]), .oup_ready_i(ordy[0]), .oup_data_o(odat[0]), .oup_last_o(olast[0]),
    .oup_idx_o(oidx[0]), .busy_o(busy[0]));

  stream_rr_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW), .MAX_BEATS(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst),
    .inp_valid_i(vld[1]), .inp_ready_o(rdy_o[1]), .inp_data_i(dat[1]), .inp_last_i(lst[1]),
    .oup_valid_o(ov[1]), .oup_ready_i(ordy[1]), .oup_data_o(odat[1]), .oup_last_o(olast[1]),
    .oup_idx_o(oidx[1]), .busy_o(busy[1]));

  // ---------------- stimulus state ----------------
  logic [DW:0] bq [2*N][$];   // {last, data} beats per (instance, requester)
  int          gate [2*N];    // cycles before a requester may raise valid
  int          stall;         // cycles of forced oup_ready=0
  bit          rand_ready;
  bit          rand_gap;
  int          hlog [2][$];   // accepted grant indices per instance

  // ---------------- reference model ----------------
  int mb  [2] = '{16, 4};
  int rr  [2];
  int own [2];                // locked owner, -1 when none
  int nb  [2];                // beats accepted in current grant
  int sg  [2];
  bit sev [2];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      rr[m] = 0; own[m] = -1; nb[m] = 0; sev[m] = 1'b0;
    end
  endtask

  task automatic clear_stim();
    for (int q = 0; q < 2*N; q++) begin
      bq[q].delete();
      gate[q] = 0;
    end
    stall = 0; rand_ready = 1'b0; rand_gap = 1'b0;
    hlog[0].delete(); hlog[1].delete();
  endtask

  // Push nbeats to requester k of both instances, last every blen beats.
  task automatic load(input int k, input int nbeats, input int blen);
    logic [DW-1:0] d;
    logic          l;
    for (int i = 0; i < nbeats; i++) begin
      d = $urandom;
      l = ((i % blen) == blen - 1) || (i == nbeats - 1);
      bq[k].push_back({l, d});
      bq[N+k].push_back({l, d});
    end
  endtask

  function automatic bit any_pending();
    bit p = 1'b0;
    for (int q = 0; q < 2*N; q++) if (bq[q].size() > 0) p = 1'b1;
    return p;
  endfunction

  // ---------------- driver ----------------
  task automatic drive();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < N; k++) begin
        int q;
        q = m*N + k;
        if (bq[q].size() > 0) begin
          {lst[m][k], dat[m][k*DW +: DW]} = bq[q][0];
          vld[m][k] = (gate[q] == 0) && !(rand_gap && ($urandom_range(0, 3) == 0));
        end else begin
          lst[m][k] = 1'($urandom_range(0, 1));
          dat[m][k*DW +: DW] = $urandom;
          vld[m][k] = 1'b0;
        end
      end
      ordy[m] = rand_ready ? 1'($urandom_range(0, 1)) : (stall == 0);
    end
  endtask

  // ---------------- scoreboard check ----------------
  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      int         g;
      bit         ev;
      logic [N-1:0] er;
      int         q;
      g = -1;
      if (own[m] >= 0) g = own[m];
      else begin
        for (int i = N - 1; i >= 0; i--)
          if (vld[m][(rr[m] + i) % N]) g = (rr[m] + i) % N;
      end
      ev = !rst && (g >= 0) && vld[m][g];
      er = '0;
      if (!rst && (g >= 0) && ordy[m]) er[g] = 1'b1;
      chk($sformatf("valid[m%0d]", m), 64'(ov[m]), 64'(ev));
      chk($sformatf("ready[m%0d]", m), 64'(rdy_o[m]), 64'(er));
      chk($sformatf("busy[m%0d]", m), 64'(busy[m]), 64'(own[m] >= 0));
      if (ev) begin
        q = m*N + g;
        chk($sformatf("idx[m%0d]", m), 64'(oidx[m]), 64'(g));
        chk($sformatf("data[m%0d]", m), 64'(odat[m]), 64'(bq[q][0][DW-1:0]));
        chk($sformatf("last[m%0d]", m), 64'(olast[m]), 64'(bq[q][0][DW]));
      end
      if (rst) chk($sformatf("rst_idx[m%0d]", m), 64'(oidx[m]), 64'd0);
      sev[m] = ev;
      sg[m]  = g;
    end
  endtask

  task automatic update();
    for (int m = 0; m < 2; m++) begin
      if (sev[m]) begin
        int g;
        logic [DW:0] b;
        bit fin;
        g = sg[m];
        if (ordy[m]) begin
          hlog[m].push_back(g);
          b = bq[m*N + g].pop_front();
          nb[m] = nb[m] + 1;
          fin = b[DW] || (mb[m] != 0 && nb[m] == mb[m]);
          if (fin) begin
            own[m] = -1; nb[m] = 0; rr[m] = (g + 1) % N;
          end else begin
            own[m] = g;
          end
        end else begin
          own[m] = g;
        end
      end
    end
    for (int q = 0; q < 2*N; q++) if (gate[q] > 0) gate[q]--;
    if (stall > 0) stall--;
  endtask

  task automatic cycle();
    drive();
    #4;
    check_all();
    @(posedge clk);
    #1;
    update();
  endtask

  task automatic run_drain(input int budget);
    int c = 0;
    while (any_pending() && c < budget) begin
      cycle();
      c++;
    end
    chk("drain_timeout", 64'(any_pending()), 64'd0);
  endtask

  task automatic chk_seq(input string tag, input int m, input int exp[$]);
    chk($sformatf("%s_len[m%0d]", tag, m), 64'(hlog[m].size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < hlog[m].size(); i++)
      chk($sformatf("%s_seq%0d[m%0d]", tag, i, m), 64'(hlog[m][i]), 64'(exp[i]));
  endtask

  // Reset for 3 cycles with every requester valid.
  task automatic reset_seq();
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    clear_stim();
    repeat (3) begin
      for (int m = 0; m < 2; m++) begin
        vld[m] = '1; lst[m] = '0; ordy[m] = 1'b1;
        for (int k = 0; k < N; k++) dat[m][k*DW +: DW] = $urandom;
      end
      #4;
      check_all();
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int e0[$];
    int e1[$];
    model_reset();
    clear_stim();
    for (int m = 0; m < 2; m++) begin
      vld[m] = '0; lst[m] = '0; dat[m] = '0; ordy[m] = 1'b0;
    end

    // Reset, then round-robin with single-beat bursts.
    reset_seq();
    load(0, 2, 1); load(1, 2, 1); load(2, 1, 1); load(3, 1, 1);
    run_drain(50);
    e0 = '{0, 1, 2, 3, 0, 1};
    chk_seq("rr", 0, e0);
    chk_seq("rr", 1, e0);

    // Burst lock: requester 2 five beats, requester 3 waiting.
    reset_seq();
    load(2, 5, 5); load(3, 1, 1);
    run_drain(50);
    e0 = '{2, 2, 2, 2, 2, 3};
    e1 = '{2, 2, 2, 2, 3, 2};
    chk_seq("burst", 0, e0);
    chk_seq("burst", 1, e1);

    // Beat limit: requester 0 ten beats, requester 1 waiting.
    reset_seq();
    load(0, 10, 10); load(1, 2, 1);
    run_drain(50);
    e0 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    e1 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    chk_seq("limit", 0, e0);
    chk_seq("limit", 1, e1);

    // Backpressure: requester 1 stalled 3 cycles, requester 0 arrives late.
    reset_seq();
    load(1, 1, 1); load(0, 1, 1);
    gate[0] = 2; gate[N] = 2; stall = 3;
    run_drain(50);
    e0 = '{1, 0};
    chk_seq("bp", 0, e0);
    chk_seq("bp", 1, e0);

    // Reset mid-burst from requester 3.
    reset_seq();
    load(3, 6, 6);
    cycle();
    cycle();
    drive();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_stim();
    load(3, 2, 2); load(0, 1, 1);
    run_drain(50);
    e0 = '{0, 3, 3};
    chk_seq("midrst", 0, e0);
    chk_seq("midrst", 1, e0);

    // Randomized traffic, ready and valid gaps.
    for (int r = 0; r < 30; r++) begin
      clear_stim();
      rand_ready = 1'b1;
      rand_gap   = 1'b1;
      for (int k = 0; k < N; k++)
        load(k, $urandom_range(0, 8), $urandom_range(1, 6));
      run_drain(600);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
